// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch
// Description : Instruction fetch unit. Issues one memory read at a time
//               from a running PC, queues returned words with their address
//               and presents the oldest entry to the decode stage. A redirect
//               flushes the queue, reloads the PC and discards any read that
//               is still in flight.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               en                - allows new memory requests
//               redirect,         - flush and reload PC (word aligned)
//               redirect_pc
//               mem_req/addr/gnt  - request handshake (one outstanding)
//               mem_rvalid/rdata  - read return
//               opcode/pc_out     - head entry of the instruction queue
//               opcode_valid/     - head handshake with decode
//               opcode_ready
//               q_count           - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch #(
  parameter int            N        = 32,
  parameter int            DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   redirect,
  input  logic [N-1:0]           redirect_pc,
  output logic                   mem_req,
  output logic [N-1:0]           mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic [31:0]            opcode,
  output logic                   opcode_valid,
  input  logic                   opcode_ready,
  output logic [N-1:0]           pc_out,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  pc;
  logic [N-1:0]  req_pc;
  logic [31:0]   opc_mem [DEPTH];
  logic [N-1:0]  pc_mem  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Redirect suppresses both queue operations: the flush wins.
  assign push = (state == WAIT) && mem_rvalid && !redirect;
  assign pop  = opcode_valid && opcode_ready && !redirect;

  assign mem_addr     = pc;
  assign opcode_valid = (count != '0);
  assign q_count      = count;
  assign opcode       = opc_mem[rd_ptr];
  assign pc_out       = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        // Only one request can be outstanding and it is the only push
        // source, so checking occupancy here is enough to avoid overflow.
        if (en && !redirect && (count < FULL)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect) begin
          state_nxt = mem_gnt ? DROP : IDLE;
        end else if (mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = mem_rvalid ? IDLE : DROP;
        end else if (mem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      DROP: begin
        // The stale read must still be consumed before a new request.
        if (mem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= {redirect_pc[N-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if ((state == REQ) && mem_gnt) begin
        req_pc <= pc;
        pc     <= pc + N'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; the head is only meaningful when valid.
  always_ff @(posedge clk) begin
    if (push) begin
      opc_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]  <= req_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch
// Description : Self-checking bench for fetch: cycle table for queue fill and
//               drain, directed redirect/wrap/reset sequences, and a random
//               stream checked against an expected-entry queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;

  localparam int           N        = 32;
  localparam int           DEPTH    = 4;
  localparam logic [N-1:0] RESET_PC = '0;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   redirect;
  logic [N-1:0]           redirect_pc;
  logic                   mem_req;
  logic [N-1:0]           mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [31:0]            mem_rdata;
  logic [31:0]            opcode;
  logic                   opcode_valid;
  logic                   opcode_ready;
  logic [N-1:0]           pc_out;
  logic [$clog2(DEPTH):0] q_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .opcode_ready (opcode_ready),
    .pc_out       (pc_out),
    .q_count      (q_count)
  );

  typedef struct {
    logic        en, rdy, gnt, rv;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eov;
    logic [2:0]  eqc;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [N-1:0] pc;
    logic [31:0]  op;
  } ent_t;

  vec_t tbl[16];
  ent_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input logic [N-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic quiet_inputs();
    en           = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    opcode_ready = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_req",   {63'd0, mem_req}, 64'd0);
    chk("rst_addr",  {32'd0, mem_addr}, {32'd0, RESET_PC});
    chk("rst_count", {61'd0, q_count}, 64'd0);
    chk("rst_valid", {63'd0, opcode_valid}, 64'd0);
    rst = 1'b0;
  endtask

  // From IDLE with en=1: request, grant, return one cycle after grant.
  task automatic fetch_one(input logic [31:0] d);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    step();
    mem_rvalid = 1'b0;
  endtask

  logic [N-1:0] exp_pc;
  logic [N-1:0] pend_addr;
  bit           pend;
  bit           pend_drop;
  bit           do_pop;
  int           lat;

  initial begin
    // en rdy gnt rv | req addr ov qc pc_out
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h00,1'b0,3'd0,32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,32'h00,1'b0,3'd0,32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,32'h04,1'b0,3'd0,32'h0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h04,1'b1,3'd1,32'h0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,32'h04,1'b1,3'd1,32'h0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,32'h08,1'b1,3'd1,32'h0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h08,1'b1,3'd2,32'h0};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1,32'h08,1'b1,3'd2,32'h0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,32'h0C,1'b1,3'd2,32'h0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0C,1'b1,3'd3,32'h0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,32'h0C,1'b1,3'd3,32'h0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,32'h10,1'b1,3'd3,32'h0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h10,1'b1,3'd4,32'h0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,32'h10,1'b1,3'd4,32'h0};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,32'h10,1'b1,3'd3,32'h4};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,32'h10,1'b1,3'd3,32'h4};

    rst = 1'b1;
    quiet_inputs();
    #1;
    do_reset();

    // ---- Fill to DEPTH, hold, pop one, re-request ----
    for (int i = 0; i < 16; i++) begin
      en           = tbl[i].en;
      opcode_ready = tbl[i].rdy;
      mem_gnt      = tbl[i].gnt;
      mem_rvalid   = tbl[i].rv;
      mem_rdata    = 32'h0000_0013;
      chk($sformatf("tbl%0d_req", i),   {63'd0, mem_req}, {63'd0, tbl[i].ereq});
      chk($sformatf("tbl%0d_addr", i),  {32'd0, mem_addr}, {32'd0, tbl[i].eaddr});
      chk($sformatf("tbl%0d_valid", i), {63'd0, opcode_valid}, {63'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_count", i), {61'd0, q_count}, {61'd0, tbl[i].eqc});
      if (tbl[i].eov) begin
        chk($sformatf("tbl%0d_pc", i), {32'd0, pc_out}, {32'd0, tbl[i].epc});
        chk($sformatf("tbl%0d_op", i), {32'd0, opcode}, 64'h13);
      end
      step();
    end

    // ---- Redirect during WAIT, stale return two cycles later ----
    do_reset();
    en = 1'b1;
    fetch_one(32'hA0A0_0000);
    chk("A_count1", {61'd0, q_count}, 64'd1);
    step();
    chk("A_req", {63'd0, mem_req}, 64'd1);
    chk("A_addr", {32'd0, mem_addr}, 64'h4);
    mem_gnt = 1'b1;
    step();
    mem_gnt     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("A_flush", {61'd0, q_count}, 64'd0);
    chk("A_flush_valid", {63'd0, opcode_valid}, 64'd0);
    chk("A_drop_req0", {63'd0, mem_req}, 64'd0);
    chk("A_newpc", {32'd0, mem_addr}, 64'h100);
    step();
    chk("A_drop_req1", {63'd0, mem_req}, 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk("A_stale", {61'd0, q_count}, 64'd0);
    step();
    chk("A_rereq", {63'd0, mem_req}, 64'd1);
    chk("A_readdr", {32'd0, mem_addr}, 64'h100);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA1A1_0001;
    step();
    mem_rvalid = 1'b0;
    chk("A_pc", {32'd0, pc_out}, 64'h100);
    chk("A_op", {32'd0, opcode}, 64'hA1A1_0001);
    chk("A_count", {61'd0, q_count}, 64'd1);

    // ---- Redirect on the grant cycle ----
    step();
    chk("B_req", {63'd0, mem_req}, 64'd1);
    chk("B_addr", {32'd0, mem_addr}, 64'h104);
    mem_gnt     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    mem_gnt  = 1'b0;
    redirect = 1'b0;
    chk("B_count", {61'd0, q_count}, 64'd0);
    chk("B_newpc", {32'd0, mem_addr}, 64'h200);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("B_drop_req%0d", i), {63'd0, mem_req}, 64'd0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    step();
    mem_rvalid = 1'b0;
    chk("B_idle_req", {63'd0, mem_req}, 64'd0);
    chk("B_stale", {61'd0, q_count}, 64'd0);
    step();
    chk("B_rereq", {63'd0, mem_req}, 64'd1);
    chk("B_readdr", {32'd0, mem_addr}, 64'h200);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hB1B1_0001;
    step();
    mem_rvalid = 1'b0;
    chk("B_pc", {32'd0, pc_out}, 64'h200);
    chk("B_op", {32'd0, opcode}, 64'hB1B1_0001);

    // ---- PC wrap, fill, push+pop together, en dropped mid-request ----
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("C_count0", {61'd0, q_count}, 64'd0);
    chk("C_idle_req", {63'd0, mem_req}, 64'd0);
    chk("C_align", {32'd0, mem_addr}, 64'hFFFF_FFFC);
    step();
    chk("C_req", {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("C_wrap", {32'd0, mem_addr}, 64'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC000_0000;
    step();
    mem_rvalid = 1'b0;
    fetch_one(32'hC000_0001);
    fetch_one(32'hC000_0002);
    fetch_one(32'hC000_0003);
    chk("C_full", {61'd0, q_count}, 64'd4);
    chk("C_head_pc", {32'd0, pc_out}, 64'hFFFF_FFFC);
    chk("C_head_op", {32'd0, opcode}, 64'hC000_0000);
    step();
    chk("C_full_noreq", {63'd0, mem_req}, 64'd0);
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    chk("C_pop_count", {61'd0, q_count}, 64'd3);
    chk("C_pop_pc", {32'd0, pc_out}, 64'h0);
    step();
    chk("C_req2", {63'd0, mem_req}, 64'd1);
    chk("C_addr2", {32'd0, mem_addr}, 64'hC);
    en      = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'hC000_0004;
    opcode_ready = 1'b1;
    step();
    mem_rvalid   = 1'b0;
    opcode_ready = 1'b0;
    chk("C_pushpop_count", {61'd0, q_count}, 64'd3);
    step();
    chk("C_en0_noreq", {63'd0, mem_req}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("C_drain%0d_pc", i), {32'd0, pc_out}, 64'(32'h4 + 32'h4 * i));
      chk($sformatf("C_drain%0d_op", i), {32'd0, opcode}, 64'(32'hC000_0002 + i));
      opcode_ready = 1'b1;
      step();
      opcode_ready = 1'b0;
    end
    chk("C_empty", {63'd0, opcode_valid}, 64'd0);

    // ---- Reset while WAIT, late return ignored ----
    do_reset();
    en = 1'b1;
    fetch_one(32'hD000_0000);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    en      = 1'b0;
    rst     = 1'b1;
    #1;
    chk("D_async_count", {61'd0, q_count}, 64'd0);
    chk("D_async_valid", {63'd0, opcode_valid}, 64'd0);
    chk("D_async_addr", {32'd0, mem_addr}, {32'd0, RESET_PC});
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hD000_0001;
    step();
    mem_rvalid = 1'b0;
    chk("D_late_count", {61'd0, q_count}, 64'd0);
    chk("D_late_valid", {63'd0, opcode_valid}, 64'd0);
    chk("D_late_req", {63'd0, mem_req}, 64'd0);
    chk("D_late_addr", {32'd0, mem_addr}, {32'd0, RESET_PC});

    // ---- Random stream against the expected-entry queue ----
    do_reset();
    exp_pc    = RESET_PC;
    pend      = 1'b0;
    pend_drop = 1'b0;
    lat       = 0;
    sb.delete();
    for (int c = 0; c < 500; c++) begin
      en           = ($urandom_range(0, 9) != 0);
      opcode_ready = ($urandom_range(0, 1) != 0);
      redirect     = ($urandom_range(0, 29) == 0);
      redirect_pc  = $urandom;
      mem_gnt      = mem_req && !pend && ($urandom_range(0, 2) != 0);
      mem_rvalid   = pend && (lat == 0);
      mem_rdata    = mem_rvalid ? dat(pend_addr) : 32'h0;

      chk("S_addr",  {32'd0, mem_addr}, {32'd0, exp_pc});
      chk("S_count", {61'd0, q_count}, 64'(sb.size()));
      chk("S_valid", {63'd0, opcode_valid}, {63'd0, (sb.size() != 0)});
      do_pop = (sb.size() != 0) && opcode_ready;
      if (do_pop) begin
        chk("S_pc", {32'd0, pc_out}, {32'd0, sb[0].pc});
        chk("S_op", {32'd0, opcode}, {32'd0, sb[0].op});
      end

      if (mem_rvalid) begin
        pend = 1'b0;
        if (!pend_drop && !redirect) begin
          sb.push_back('{pend_addr, dat(pend_addr)});
        end
      end else if (pend) begin
        lat--;
      end
      if (do_pop && !redirect) begin
        void'(sb.pop_front());
      end
      if (mem_gnt) begin
        pend      = 1'b1;
        pend_addr = exp_pc;
        pend_drop = redirect;
        lat       = $urandom_range(0, 2);
        exp_pc    = exp_pc + 32'd4;
      end
      if (redirect) begin
        sb.delete();
        if (pend) begin
          pend_drop = 1'b1;
        end
        exp_pc = {redirect_pc[N-1:2], 2'b00};
      end
      step();
    end
    quiet_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
